// File: rtl/m_ext_pkg.sv
// Shared types and constants for the M-extension divide path.
package m_ext_pkg;

  localparam int DIV_XLEN = 32;
  localparam logic [DIV_XLEN-1:0] DIV_MOST_NEG = {1'b1, {(DIV_XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [2:0] {
    IDLE,
    SPECIAL,
    START,
    WAIT,
    FIXUP,
    RESP
  } div_seq_state_t;

endpackage

// File: rtl/div_sign_fixup.sv
// Applies RISC-V sign rules to an unsigned quotient/remainder pair and
// selects the requested half.
module div_sign_fixup #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] r,
  input  logic             a_neg,
  input  logic             b_neg,
  input  logic             is_signed,
  input  logic             is_rem,
  output logic [WIDTH-1:0] result
);

  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Remainder takes the dividend's sign; quotient is negative when signs differ.
  assign neg_q  = is_signed && (a_neg ^ b_neg);
  assign neg_r  = is_signed && a_neg;
  assign q_fix  = neg_q ? (~q + 1'b1) : q;
  assign r_fix  = neg_r ? (~r + 1'b1) : r;
  assign result = is_rem ? r_fix : q_fix;

endmodule

// File: rtl/div_sequencer.sv
// Issue/sequencing controller between EX and the iterative divider core,
// with special-case bypass and a one-entry result cache.
module div_sequencer
  import m_ext_pkg::*;
#(
  parameter int WIDTH = DIV_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_seq_state_t   state;
  logic             op_signed;
  logic             op_rem;
  logic             wait_first;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             cache_valid;
  logic             cache_signed;
  logic [WIDTH-1:0] cache_a;
  logic [WIDTH-1:0] cache_b;
  logic [WIDTH-1:0] cache_q;
  logic [WIDTH-1:0] cache_r;

  logic             accept;
  logic             req_signed;
  logic             req_special;
  logic             req_hit;
  logic [WIDTH-1:0] special_result;
  logic [WIDTH-1:0] fix_result;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  assign accept      = req_valid && req_ready && !flush;
  assign req_signed  = (req_op == DIV) || (req_op == REM);
  assign req_special = (req_b == '0) ||
                       (req_signed && (req_a == MOST_NEG) && (req_b == '1));
  assign req_hit     = cache_valid && (req_a == cache_a) && (req_b == cache_b) &&
                       (req_signed == cache_signed);

  assign special_result = (b_q == '0) ? (op_rem ? a_q : '1)
                                      : (op_rem ? '0  : MOST_NEG);

  // The cache always holds the magnitudes of the last core run, so both the
  // post-core and the cache-hit paths fix up from the same registers.
  div_sign_fixup #(.WIDTH(WIDTH)) u_fixup (
    .q         (cache_q),
    .r         (cache_r),
    .a_neg     (a_q[WIDTH-1]),
    .b_neg     (b_q[WIDTH-1]),
    .is_signed (op_signed),
    .is_rem    (op_rem),
    .result    (fix_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      op_signed    <= 1'b0;
      op_rem       <= 1'b0;
      wait_first   <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_q      <= '0;
      cache_r      <= '0;
    end else if (flush && state != IDLE) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      div_start  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q       <= req_a;
            b_q       <= req_b;
            op_signed <= req_signed;
            op_rem    <= req_op[1];
            req_ready <= 1'b0;
            if (req_special) begin
              state <= SPECIAL;
            end else if (req_hit) begin
              state <= FIXUP;
            end else begin
              state        <= START;
              div_start    <= 1'b1;
              div_dividend <= magnitude(req_a, req_signed);
              div_divisor  <= magnitude(req_b, req_signed);
            end
          end
        end
        SPECIAL: begin
          resp_data  <= special_result;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        START: begin
          div_start  <= 1'b0;
          wait_first <= 1'b1;
          state      <= WAIT;
        end
        // div_done is a level left over from the previous run for one cycle.
        WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (div_done) begin
            cache_valid  <= 1'b1;
            cache_signed <= op_signed;
            cache_a      <= a_q;
            cache_b      <= b_q;
            cache_q      <= div_quotient;
            cache_r      <= div_remainder;
            state        <= FIXUP;
          end
        end
        FIXUP: begin
          resp_data  <= fix_result;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized scoreboard bench for div_sequencer with a behavioural divider core.
module tb_div_sequencer;
  import m_ext_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          c0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_done = 1'b0;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int core_lat = 3;
  exp_t sb_q[$];

  logic        cm_valid = 1'b0;
  logic [31:0] cm_a = '0;
  logic [31:0] cm_b = '0;
  logic        cm_sgn = 1'b0;
  logic [31:0] exp_mag_a = '0;
  logic [31:0] exp_mag_b = '0;

  logic        core_busy = 1'b0;
  int          core_cnt = 0;
  logic [31:0] core_a = '0;
  logic [31:0] core_b = '0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider core: done stays high one cycle past a new start, then rises
  // core_lat edges after the start was sampled.
  always @(posedge clk) begin
    if (div_start) begin
      core_busy <= 1'b1;
      core_cnt  <= 0;
      core_a    <= div_dividend;
      core_b    <= div_divisor;
    end else if (core_busy) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 == 1) div_done <= 1'b0;
      if (core_cnt + 1 == core_lat) begin
        div_done      <= 1'b1;
        div_quotient  <= (core_b == 0) ? 32'hFFFF_FFFF : core_a / core_b;
        div_remainder <= (core_b == 0) ? core_a : core_a % core_b;
        core_busy     <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit     sgn;
    bit     rem;
    longint sa;
    longint sb;
    sgn = !op[0];
    rem = op[1];
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == DIV_MOST_NEG && b == 32'hFFFF_FFFF) return rem ? 32'h0 : DIV_MOST_NEG;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? a % b : a / b;
  endfunction

  // Monitor: pops the scoreboard on the first cycle of each response and
  // holds it to that value until the handshake.
  initial begin
    bit          in_resp;
    logic [31:0] held;
    exp_t        e;
    in_resp = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        start_cnt++;
        checkOutput("core_dividend", div_dividend, exp_mag_a);
        checkOutput("core_divisor", div_divisor, exp_mag_b);
      end
      if (resp_valid) begin
        if (!in_resp) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_resp", 32'(resp_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            checkOutput("resp_data", resp_data, e.data);
            checkOutput("resp_latency", 32'(cyc - e.c0), 32'(e.lat));
          end
          in_resp = 1;
          held = resp_data;
        end else begin
          checkOutput("resp_stable", resp_data, held);
          checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        end
        if (resp_ready) begin
          in_resp = 0;
          done_cnt++;
        end
      end else begin
        in_resp = 0;
      end
    end
  end

  // mode 0: normal request; mode 1: flush in WAIT; mode 2: reset in WAIT.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int hold, input int mode);
    bit   sgn;
    bit   special;
    bit   hit;
    int   lat;
    int   starts0;
    int   dn0;
    int   waited;
    exp_t e;
    sgn = !op[0];
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready) checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
    special = (b == 0) || (sgn && a == DIV_MOST_NEG && b == 32'hFFFF_FFFF);
    hit = !special && cm_valid && cm_a == a && cm_b == b && cm_sgn == sgn;
    core_lat = (mode == 0) ? int'($urandom_range(2, 6)) : 5;
    lat = (special || hit) ? 2 : 4 + core_lat;
    exp_mag_a = (sgn && a[31]) ? -a : a;
    exp_mag_b = (sgn && b[31]) ? -b : b;
    if (mode == 0) begin
      e.data = ref_result(op, a, b);
      e.c0 = cyc;
      e.lat = lat;
      sb_q.push_back(e);
      if (!special && !hit) begin
        cm_valid = 1;
        cm_a = a;
        cm_b = b;
        cm_sgn = sgn;
      end
    end
    starts0 = start_cnt;
    dn0 = done_cnt;
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 0;
    if (mode != 0) begin
      @(posedge clk); #1;
      if (mode == 1) flush = 1;
      else rst = 0;
      @(posedge clk); #1;
      flush = 0;
      rst = 1;
      checkOutput("kill_req_ready", 32'(req_ready), 32'd1);
      checkOutput("kill_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("kill_div_start", 32'(div_start), 32'd0);
      if (mode == 2) begin
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_dividend", div_dividend, 32'd0);
        checkOutput("rst_divisor", div_divisor, 32'd0);
        cm_valid = 0;
      end
      repeat (8) begin
        @(posedge clk); #1;
      end
      checkOutput("kill_start_count", 32'(start_cnt - starts0), 32'd1);
    end else begin
      if (hold > 0) begin
        waited = 0;
        while (!resp_valid && waited < 60) begin
          @(posedge clk); #1;
          waited++;
        end
        repeat (hold) begin
          @(posedge clk); #1;
        end
        resp_ready = 1;
      end
      waited = 0;
      while (done_cnt == dn0 && waited < 80) begin
        @(posedge clk); #1;
        waited++;
      end
      checkOutput("resp_done", 32'(done_cnt - dn0), 32'd1);
      checkOutput("start_count", 32'(start_cnt - starts0), (special || hit) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prev_a;
    logic [31:0] prev_b;
    int          starts0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_resp_data", resp_data, 32'd0);
    checkOutput("reset_div_start", 32'(div_start), 32'd0);
    checkOutput("reset_dividend", div_dividend, 32'd0);
    checkOutput("reset_divisor", div_divisor, 32'd0);

    $display("[TB] directed sequence");
    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    applyStimulus(2'b01, 32'h10, 32'd0, 0, 0);
    applyStimulus(2'b11, 32'h10, 32'd0, 0, 0);
    applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(2'b01, 32'd100, 32'd7, 5, 0);
    applyStimulus(2'b01, 32'd1000, 32'd3, 0, 0);
    applyStimulus(2'b01, 32'd100, 32'd7, 0, 1);
    applyStimulus(2'b11, 32'd100, 32'd7, 0, 0);
    applyStimulus(2'b01, 32'd55, 32'd4, 0, 2);
    applyStimulus(2'b11, 32'd100, 32'd7, 0, 0);
    applyStimulus(2'b01, 32'd55, 32'd4, 0, 0);

    starts0 = start_cnt;
    req_op = 2'b01;
    req_a = 32'd9;
    req_b = 32'd2;
    req_valid = 1;
    flush = 1;
    @(posedge clk); #1;
    req_valid = 0;
    flush = 0;
    checkOutput("flush_idle_ready", 32'(req_ready), 32'd1);
    checkOutput("flush_idle_start", 32'(div_start), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("flush_idle_no_start", 32'(start_cnt - starts0), 32'd0);

    $display("[TB] random sequence");
    prev_a = 32'd1;
    prev_b = 32'd1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = DIV_MOST_NEG; b = 32'hFFFF_FFFF; end
        2, 3: begin a = prev_a; b = prev_b; end
        4: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        5: begin a = -$urandom_range(0, 200); b = $urandom_range(1, 20); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      applyStimulus(2'($urandom_range(0, 3)), a, b,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 0);
      prev_a = a;
      prev_b = b;
    end

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Issue/sequencing controller for the M-extension iterative divider core; sits between the EX stage and the divider datapath.
- Accepts DIV/DIVU/REM/REMU requests, resolves the special cases (divide-by-zero, signed overflow) without invoking the core, converts signed operands to magnitudes, starts the core, waits for its done, applies sign fix-up and returns one result per request.
- Holds a one-entry result cache so a DIV/REM pair with identical operands and signedness costs one core run.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low: state is cleared on a rising clk edge while rst==0.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- req_a  in  WIDTH  dividend (rs1).
- req_b  in  WIDTH  divisor (rs2).
- flush  in  1  kill the in-flight operation (pipeline redirect).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  WIDTH  quotient or remainder per op.
- div_start  out  1  one-cycle start pulse to the divider core.
- div_dividend  out  WIDTH  unsigned dividend magnitude; stable from start until done.
- div_divisor  out  WIDTH  unsigned divisor magnitude; stable from start until done.
- div_done  in  1  core finished; level, held until next start.
- div_quotient  in  WIDTH  unsigned quotient, valid while div_done.
- div_remainder  in  WIDTH  unsigned remainder, valid while div_done.

Behaviour:
- Reset: state IDLE; req_ready=1, resp_valid=0, resp_data=0, div_start=0, div_dividend=0, div_divisor=0, cache_valid=0.
- Accept: req_valid && req_ready at an edge latches op, a, b. signed = ~op[0]; is_rem = op[1].
- States:
  - IDLE: waits for a request. On accept, next state is SPECIAL if b==0 or (signed && a==1<<(WIDTH-1) && b=='1); else RESP via cache hit if cache_valid && a,b,signed match the cached entry; else START.
  - SPECIAL: computes result (see below) -> RESP.
  - START: div_start=1 for exactly this cycle; operand magnitudes are driven = |a|, |b| when signed, raw otherwise -> WAIT.
  - WAIT: ignores div_done in the first cycle after start (stale level from the prior op). Thereafter, on div_done: latch quotient/remainder into the cache, set cache_valid -> FIXUP.
  - FIXUP: signed quotient is negated iff sign(a)!=sign(b); signed remainder is negated iff a<0. Selects per is_rem -> RESP.
  - RESP: resp_valid=1, resp_data stable; on resp_ready -> IDLE.
- Special results: b==0 gives quotient '1 (all ones) and remainder a, for both signedness. Overflow gives quotient 1<<(WIDTH-1) and remainder 0. The cache is not updated by special cases.
- Cache hit: the cached unsigned quotient/remainder are fixed up with the current request's signs. Request accept to resp_valid is 2 cycles.
- Latency, request accept edge to resp_valid high:
  - special: 2 cycles.
  - cache hit: 2 cycles.
  - core path: 4 + core latency cycles.
- Single outstanding operation: req_ready=0 from accept until the RESP handshake completes.
- flush:
  - Any state other than IDLE returns to IDLE at the next edge.
  - resp_valid drops; no result is produced for the killed op.
  - A flush in WAIT leaves the cache untouched (cache_valid unchanged, entry not overwritten). The core finishes silently.
  - flush has priority over div_done and resp_ready in the same cycle.
  - flush while in IDLE with req_valid blocks the accept in that cycle.
- Reset mid-operation: returns to IDLE, invalidates the cache, drives div_start=0.
- Arithmetic: negation is two's complement at WIDTH bits. |1<<(WIDTH-1)| = 1<<(WIDTH-1), treated as unsigned.

Decomposition:
- Shared package m_ext_pkg holds:
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - div_seq_state_t enum (IDLE, SPECIAL, START, WAIT, FIXUP, RESP).
  - constant for the most-negative value.
- One sub-module is natural: div_sign_fixup, combinational. Inputs are unsigned q/r, sign(a), sign(b), signed and is_rem; output is the selected signed result. It is shared by the FIXUP and cache-hit paths.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2 -> core sees 7/2; resp_data=0xFFFFFFFD (-3). Then REM with the same a,b -> cache hit, resp_data=0xFFFFFFFF (-1), 2-cycle latency, no div_start.
- DIVU a=0x10, b=0 -> resp_data=0xFFFFFFFF with 2-cycle latency; REMU a=0x10, b=0 -> resp_data=0x10; div_start never asserted.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; the core is not started.
- DIVU a=100, b=7 with resp_ready held low 5 cycles -> resp_valid and resp_data=14 stable throughout; req_ready=0 until the handshake.
- flush in WAIT during DIVU 100/7 -> IDLE next cycle, no resp_valid. Then REMU 100/7 -> cache miss, a new div_start, resp_data=2.
- rst=0 for one edge while in WAIT -> all outputs at reset values next cycle; a repeated identical request misses the cache.
